// File: rtl/text_pixel_compositor.sv
// Text overlay compositor: realigns video timing with the text pipeline and picks black/fg/bg per pixel.
// Optional glyph blink is enabled by defining TEXT_PIXEL_COMPOSITOR_BLINK_EN.
module text_pixel_compositor #(
    parameter int unsigned COLOUR_BITS  = 8,
    parameter int unsigned TEXT_LATENCY = 2,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                     i_clk_pxl,
    input  logic                     i_rst_n,
    input  logic                     i_hsync,
    input  logic                     i_vsync,
    input  logic                     i_de,
    input  logic                     i_text_dv,
    input  logic                     i_text_data,
    input  logic                     i_text_en,
    input  logic [3*COLOUR_BITS-1:0] i_fg_rgb,
    input  logic [3*COLOUR_BITS-1:0] i_bg_rgb,
    output logic [COLOUR_BITS-1:0]   o_r,
    output logic [COLOUR_BITS-1:0]   o_g,
    output logic [COLOUR_BITS-1:0]   o_b,
    output logic                     o_hsync,
    output logic                     o_vsync,
    output logic                     o_de,
    output logic                     o_frame_start
);
    localparam int unsigned STAGES = TEXT_LATENCY + 1;
    localparam int unsigned RGB_W  = 3 * COLOUR_BITS;

    if (TEXT_LATENCY > 15 || BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_cfg
        $error("text_pixel_compositor: parameter out of range");
    end

    // Timing delay line, each stage packed {hsync, vsync, de}
    logic [2:0] sync_dly [STAGES];
    logic       de_aligned;

    always_ff @(posedge i_clk_pxl or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) sync_dly[i] <= '0;
        end else begin
            sync_dly[0] <= {i_hsync, i_vsync, i_de};
            for (int i = 1; i < int'(STAGES); i++) sync_dly[i] <= sync_dly[i-1];
        end
    end

    // de as it stands when the matching text bit arrives
    if (TEXT_LATENCY == 0) begin : g_lat0
        assign de_aligned = i_de;
    end else begin : g_latn
        assign de_aligned = sync_dly[TEXT_LATENCY-1][0];
    end

    assign o_hsync = sync_dly[STAGES-1][2];
    assign o_vsync = sync_dly[STAGES-1][1];
    assign o_de    = sync_dly[STAGES-1][0];

    logic vsync_q;

    always_ff @(posedge i_clk_pxl or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vsync_q       <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            vsync_q       <= i_vsync;
            o_frame_start <= i_vsync & ~vsync_q;
        end
    end

    // Colours are latched once per frame so mid-frame writes never tear the picture
    logic [RGB_W-1:0] fg_sh;
    logic [RGB_W-1:0] bg_sh;

    always_ff @(posedge i_clk_pxl or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fg_sh <= '0;
            bg_sh <= '0;
        end else if (o_frame_start) begin
            fg_sh <= i_fg_rgb;
            bg_sh <= i_bg_rgb;
        end
    end

`ifdef TEXT_PIXEL_COMPOSITOR_BLINK_EN
    logic [7:0] frame_cnt;
    logic       visible;

    always_ff @(posedge i_clk_pxl or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt <= '0;
            visible   <= 1'b1;
        end else if (o_frame_start) begin
            if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                visible   <= ~visible;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
`else
    logic visible;
    assign visible = 1'b1;
`endif

    logic             text_on_c;
    logic [RGB_W-1:0] pix_c;
    logic [RGB_W-1:0] rgb_q;

    always_comb begin
        pix_c     = '0;
        text_on_c = i_text_en & i_text_dv & i_text_data & visible;
        if (de_aligned) pix_c = text_on_c ? fg_sh : bg_sh;
    end

    always_ff @(posedge i_clk_pxl or negedge i_rst_n) begin
        if (!i_rst_n) rgb_q <= '0;
        else          rgb_q <= pix_c;
    end

    assign o_r = rgb_q[RGB_W-1 -: COLOUR_BITS];
    assign o_g = rgb_q[2*COLOUR_BITS-1 -: COLOUR_BITS];
    assign o_b = rgb_q[COLOUR_BITS-1:0];
endmodule

// File: tb/tb_text_pixel_compositor.sv
// Randomised bench for text_pixel_compositor with a cycle-level reference model and directed literal checks.
`timescale 1ns/1ps
module tb_text_pixel_compositor;
    localparam int unsigned CB  = 8;
    localparam int unsigned LAT = 2;
    localparam int unsigned BF  = 30;
    localparam int H_TOT = 16;
    localparam int H_ACT = 10;
    localparam int V_TOT = 6;
    localparam int V_ACT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hs = 1'b0, vs = 1'b0, de = 1'b0, dv = 1'b0, data = 1'b0, en = 1'b0;
    logic [23:0] fg = '0, bg = '0;
    logic [CB-1:0] r, g, b;
    logic ohs, ovs, ode, ofs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    text_pixel_compositor #(
        .COLOUR_BITS(CB), .TEXT_LATENCY(LAT), .BLINK_FRAMES(BF)
    ) dut (
        .i_clk_pxl(clk), .i_rst_n(rst_n),
        .i_hsync(hs), .i_vsync(vs), .i_de(de),
        .i_text_dv(dv), .i_text_data(data), .i_text_en(en),
        .i_fg_rgb(fg), .i_bg_rgb(bg),
        .o_r(r), .o_g(g), .o_b(b),
        .o_hsync(ohs), .o_vsync(ovs), .o_de(ode), .o_frame_start(ofs)
    );

    // Reference model: outputs are inputs seen LAT+1 edges ago, colour from per-frame latched shadows
    logic        h_hs [32];
    logic        h_vs [32];
    logic        h_de [32];
    int          n = 1000;
    int          good_run = 0;
    int          fs_cnt = 0;
    logic [23:0] sh_fg = '0, sh_bg = '0;
    logic        fs_prev = 1'b0;
    logic [2:0]  exp_sync;
    logic [23:0] exp_rgb;
    logic        exp_fs;
    logic        vis, text_on, prev_vs;
    int          p;

    initial begin
        forever begin
            @(posedge clk);
            n++;
            if (!rst_n) begin
                good_run = 0;
                sh_fg = '0; sh_bg = '0; fs_cnt = 0; fs_prev = 1'b0;
                exp_sync = '0; exp_rgb = '0; exp_fs = 1'b0;
            end else begin
                good_run++;
                h_hs[n % 32] = hs; h_vs[n % 32] = vs; h_de[n % 32] = de;
                if (good_run >= int'(LAT) + 1) begin
                    p = (n - int'(LAT)) % 32;
                    exp_sync = {h_hs[p], h_vs[p], h_de[p]};
                end else begin
                    exp_sync = '0;
                end
`ifdef TEXT_PIXEL_COMPOSITOR_BLINK_EN
                vis = ((fs_cnt / int'(BF)) % 2) == 0;
`else
                vis = 1'b1;
`endif
                text_on = en & dv & data & vis;
                exp_rgb = exp_sync[0] ? (text_on ? sh_fg : sh_bg) : 24'h0;
                if (fs_prev) begin
                    sh_fg = fg; sh_bg = bg; fs_cnt++;
                end
                prev_vs = (good_run >= 2) ? h_vs[(n - 1) % 32] : 1'b0;
                exp_fs  = vs & ~prev_vs;
                fs_prev = exp_fs;
            end
            #1;
            checks++;
            if ({ohs, ovs, ode} !== exp_sync || {r, g, b} !== exp_rgb || ofs !== exp_fs) begin
                errors++;
                $display("FAIL model_cycle %0d: got hs/vs/de=%03b rgb=%06h fs=%0b, expected hs/vs/de=%03b rgb=%06h fs=%0b",
                         n, {ohs, ovs, ode}, {r, g, b}, ofs, exp_sync, exp_rgb, exp_fs);
            end
        end
    end

    task automatic lit(input string nm, input logic exp_de, input logic [23:0] exp_c);
        checks++;
        if (ode !== exp_de || {r, g, b} !== exp_c) begin
            errors++;
            $display("FAIL %s: got de=%0b rgb=%06h, expected de=%0b rgb=%06h", nm, ode, {r, g, b}, exp_de, exp_c);
        end
    endtask

    task automatic chk_fs(input string nm, input logic exp_v);
        checks++;
        if (ofs !== exp_v) begin
            errors++;
            $display("FAIL %s: got frame_start=%0b, expected %0b", nm, ofs, exp_v);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        checks++;
        if ({ohs, ovs, ode, ofs, r, g, b} !== '0) begin
            errors++;
            $display("FAIL %s: got hs/vs/de/fs=%04b rgb=%06h, expected all 0", nm, {ohs, ovs, ode, ofs}, {r, g, b});
        end
    endtask

    // Video timing and text source driver
    logic dq [16];
    int   h = 0, v = V_TOT - 2, frame = -1, mode = 0;
    logic hpol = 1'b0;
    logic base;

    initial begin
        for (int k = 0; k < 16; k++) dq[k] = 1'b0;
        fg = 24'hFFFFFF; bg = 24'h000080; en = 1'b1; rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        while (frame < 45) begin
            if (h == 0 && v == 0) begin
                frame++;
                if (frame == 2)      mode = 1;
                else if (frame == 3) mode = 2;
                else if (frame == 4) mode = 3;
                else if (frame >= 7) mode = 4;
                else                 mode = 0;
                en   = (mode == 2) ? 1'b0 : (mode == 4) ? ($urandom_range(0, 3) != 0) : 1'b1;
                hpol = (mode == 4) ? 1'($urandom % 2) : 1'b0;
            end
            de = (h < H_ACT) && (v < V_ACT);
            vs = (v == V_TOT - 1);
            hs = ((h >= 12) && (h < 14)) ^ hpol;
            for (int k = 15; k > 0; k--) dq[k] = dq[k-1];
            dq[0] = de;
            base  = dq[LAT];
            case (mode)
                0: begin dv = 1'b1; data = 1'b1; end
                1: begin dv = base; data = 1'b0; end
                2: begin dv = base; data = 1'b1; end
                3: begin dv = 1'b0; data = 1'b1; end
                default: begin
                    dv   = base & (($urandom % 8) != 0);
                    data = 1'($urandom % 2);
                    if (($urandom % 50) == 0) fg = 24'($urandom);
                    if (($urandom % 50) == 0) bg = 24'($urandom);
                end
            endcase

            if (frame == -1 && v == V_TOT - 1 && h == 1) chk_fs("frame_start_pulse", 1'b1);
            if (frame == -1 && v == V_TOT - 1 && h == 2) chk_fs("frame_start_one_cycle", 1'b0);
            if (frame == 0) begin
                if (v == 2 && h == 0) fg = 24'hFF0000;
                if (v == 0 && h == int'(LAT))      lit("de_not_early", 1'b0, 24'h0);
                if (v == 0 && h == int'(LAT) + 1)  lit("first_pixel_fg", 1'b1, 24'hFFFFFF);
                if (v == 0 && h == int'(LAT) + 12) lit("blank_text_black", 1'b0, 24'h0);
                if (v == 3 && h == int'(LAT) + 1)  lit("shadow_holds_fg", 1'b1, 24'hFFFFFF);
            end
            if (frame == 1 && v == 0 && h == int'(LAT) + 1) lit("shadow_new_fg", 1'b1, 24'hFF0000);
            if (frame == 2 && v == 1 && h == int'(LAT) + 5) lit("bg_pixel", 1'b1, 24'h000080);
            if (frame == 3 && v == 2 && h == int'(LAT) + 4) lit("text_disabled_bg", 1'b1, 24'h000080);
            if (frame == 4 && v == 1 && h == int'(LAT) + 1) lit("dv_low_bg", 1'b1, 24'h000080);
            if (frame == 5) begin
                if (v == 1 && h == 4) begin
                    rst_n = 1'b0;
                    #1 chk_all_zero("reset_immediate");
                end
                if (v == 1 && h == 7) rst_n = 1'b1;
                if (v == 2 && h == int'(LAT) + 1) lit("black_after_reset", 1'b1, 24'h0);
            end
            if (frame == 6 && v == 0 && h == int'(LAT) + 1) lit("colour_after_reset", 1'b1, 24'hFF0000);

            @(negedge clk);
            h++;
            if (h == H_TOT) begin
                h = 0;
                v = (v + 1) % V_TOT;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 2 ms");
        $fatal(1);
    end
endmodule
